// File: rtl/dice_round_ctrl.sv
// dice_round_ctrl: initiator side of the dice-throw round handshake.
// Synchronises and debounces both player buttons, drives start1/start2 to the
// roll-delay timer, tracks the round number and ends the game after the last
// round. Optional build macro AUTO_RESTART_EN lets a both-button press in DONE
// start a new game; without it DONE is terminal until rst_n.
module dice_round_ctrl #(
    parameter int unsigned DEB_CYCLES = 1000000,
    parameter int unsigned ROUNDS     = 3,
    parameter int unsigned ACK_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn1_n,
    input  logic       btn2_n,
    input  logic       is_wait,
    input  logic       is_final_finish,
    output logic       start1,
    output logic       start2,
    output logic       is_final,
    output logic [3:0] round_idx,
    output logic       game_over,
    output logic       ack_err
);

    typedef enum logic [2:0] {ARM, HOLD, WAIT_ACK, ROLL, DONE} state_t;

    localparam int unsigned DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam int unsigned AW = (ACK_CYCLES > 1) ? $clog2(ACK_CYCLES) : 1;
    localparam logic [DW-1:0] DEB_LAST       = DW'(DEB_CYCLES - 1);
    localparam logic [AW-1:0] ACK_LAST       = AW'(ACK_CYCLES - 1);
    localparam logic [3:0]    LAST_ROUND     = 4'(ROUNDS - 1);
    localparam logic          FINAL_AT_RESET = (ROUNDS == 1);

    logic [1:0]    meta_n, sync_n;
    logic          btn1, btn2;
    logic [DW-1:0] deb_cnt1, deb_cnt2;

    state_t        state, state_nxt;
    logic          start1_nxt, start2_nxt, is_final_nxt, game_over_nxt, ack_err_nxt;
    logic [3:0]    round_nxt;
    logic [AW-1:0] ack_cnt, ack_cnt_nxt;
    logic          arm_block;

    // Two-flop synchroniser followed by a per-button debouncer; the counter
    // only advances while the sample differs from the accepted level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_n   <= '1;
            sync_n   <= '1;
            btn1     <= 1'b0;
            btn2     <= 1'b0;
            deb_cnt1 <= '0;
            deb_cnt2 <= '0;
        end else begin
            meta_n <= {btn2_n, btn1_n};
            sync_n <= meta_n;
            if (!sync_n[0] == btn1) begin
                deb_cnt1 <= '0;
            end else if (deb_cnt1 == DEB_LAST) begin
                btn1     <= !sync_n[0];
                deb_cnt1 <= '0;
            end else begin
                deb_cnt1 <= deb_cnt1 + 1'b1;
            end
            if (!sync_n[1] == btn2) begin
                deb_cnt2 <= '0;
            end else if (deb_cnt2 == DEB_LAST) begin
                btn2     <= !sync_n[1];
                deb_cnt2 <= '0;
            end else begin
                deb_cnt2 <= deb_cnt2 + 1'b1;
            end
        end
    end

`ifdef AUTO_RESTART_EN
    logic arm_block_nxt;

    // Blocks ARM presses after a restart until both buttons are released.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) arm_block <= 1'b0;
        else        arm_block <= arm_block_nxt;
    end
`else
    assign arm_block = 1'b0;
`endif

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ARM;
            start1    <= 1'b0;
            start2    <= 1'b0;
            is_final  <= FINAL_AT_RESET;
            round_idx <= '0;
            game_over <= 1'b0;
            ack_err   <= 1'b0;
            ack_cnt   <= '0;
        end else begin
            state     <= state_nxt;
            start1    <= start1_nxt;
            start2    <= start2_nxt;
            is_final  <= is_final_nxt;
            round_idx <= round_nxt;
            game_over <= game_over_nxt;
            ack_err   <= ack_err_nxt;
            ack_cnt   <= ack_cnt_nxt;
        end
    end

    // Next-state and next-output logic for the round handshake.
    always_comb begin
        state_nxt     = state;
        start1_nxt    = start1;
        start2_nxt    = start2;
        is_final_nxt  = is_final;
        round_nxt     = round_idx;
        game_over_nxt = game_over;
        ack_err_nxt   = ack_err;
        ack_cnt_nxt   = ack_cnt;
`ifdef AUTO_RESTART_EN
        arm_block_nxt = arm_block;
`endif
        case (state)
            ARM: begin
                if (arm_block) begin
`ifdef AUTO_RESTART_EN
                    if (!btn1 && !btn2) arm_block_nxt = 1'b0;
`endif
                end else begin
                    start1_nxt = start1 | btn1;
                    start2_nxt = start2 | btn2;
                end
                if (start1 && start2) state_nxt = HOLD;
            end
            HOLD: begin
                if (!start1 && !start2) begin
                    state_nxt   = WAIT_ACK;
                    ack_cnt_nxt = '0;
                end else begin
                    start1_nxt = btn1;
                    start2_nxt = btn2;
                end
            end
            WAIT_ACK: begin
                start1_nxt = 1'b0;
                start2_nxt = 1'b0;
                if (!is_wait) begin
                    state_nxt = ROLL;
                end else if (ack_cnt == ACK_LAST) begin
                    ack_err_nxt = 1'b1;
                    state_nxt   = ROLL;
                end else begin
                    ack_cnt_nxt = ack_cnt + 1'b1;
                end
            end
            ROLL: begin
                start1_nxt = 1'b0;
                start2_nxt = 1'b0;
                if (is_final) begin
                    if (is_final_finish) begin
                        game_over_nxt = 1'b1;
                        state_nxt     = DONE;
                    end
                end else if (is_wait) begin
                    round_nxt    = round_idx + 4'd1;
                    is_final_nxt = ((round_idx + 4'd1) == LAST_ROUND);
                    state_nxt    = ARM;
                end
            end
            DONE: begin
                start1_nxt = 1'b0;
                start2_nxt = 1'b0;
`ifdef AUTO_RESTART_EN
                if (btn1 && btn2) begin
                    state_nxt     = ARM;
                    round_nxt     = '0;
                    game_over_nxt = 1'b0;
                    ack_err_nxt   = 1'b0;
                    is_final_nxt  = FINAL_AT_RESET;
                    arm_block_nxt = 1'b1;
                end
`endif
            end
            default: state_nxt = ARM;
        endcase
    end

endmodule
